// File: rtl/acc_alu_seq.sv
// WIDTH-bit accumulator ALU with start/done handshake, OFF/READY/RUN/ERROR FSM and iterative shift-add MULT.
// Define ALU_SAT_EN to saturate ADD/MULT to all-ones and SUB to zero on overflow.
module acc_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             start,
  input  logic [1:0]       in_sel,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    READY = 2'b01,
    RUN   = 2'b10,
    ERROR = 2'b11
  } stateT;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpXor = 3'b010;
  localparam logic [2:0] OpNot = 3'b011;
  localparam logic [2:0] OpAdd = 3'b100;
  localparam logic [2:0] OpSub = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;

  stateT              stateQ, stateNext;
  logic [WIDTH-1:0]   accQ, accNext;
  logic [WIDTH-1:0]   resultQ, resultNext;
  logic               doneQ, doneNext;
  logic               ovfQ, ovfNext;
  logic [WIDTH-1:0]   aReg, aNext;
  logic [WIDTH-1:0]   bReg, bNext;
  logic [2:0]         opReg, opNext;
  logic [CW-1:0]      mulCnt, cntNext;
  logic [2*WIDTH-1:0] prodReg, prodNext;

  logic               finish;
  logic [WIDTH-1:0]   resVal;
  logic               ovfVal;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] partial;

  // Next-state and datapath: operands are latched in READY and stay frozen for the whole RUN.
  always_comb begin
    stateNext  = stateQ;
    accNext    = accQ;
    resultNext = resultQ;
    doneNext   = 1'b0;
    ovfNext    = ovfQ;
    aNext      = aReg;
    bNext      = bReg;
    opNext     = opReg;
    cntNext    = mulCnt;
    prodNext   = prodReg;
    finish     = 1'b0;
    resVal     = accQ;
    ovfVal     = 1'b0;
    sum        = {1'b0, aReg} + {1'b0, bReg};
    addend     = bReg[mulCnt] ? ({{WIDTH{1'b0}}, aReg} << mulCnt) : '0;
    partial    = prodReg + addend;

    case (stateQ)
      OFF: begin
        if (on) stateNext = READY;
      end
      READY: begin
        if (start) begin
          case (in_sel)
            2'b01:   aNext = operand_a;
            2'b10:   aNext = '0;
            default: aNext = accQ;
          endcase
          bNext     = operand_b;
          opNext    = op;
          ovfNext   = 1'b0;
          cntNext   = '0;
          prodNext  = '0;
          stateNext = RUN;
        end
      end
      RUN: begin
        case (opReg)
          OpAnd: begin resVal = aReg & bReg; finish = 1'b1; end
          OpOr:  begin resVal = aReg | bReg; finish = 1'b1; end
          OpXor: begin resVal = aReg ^ bReg; finish = 1'b1; end
          OpNot: begin resVal = ~aReg;       finish = 1'b1; end
          OpAdd: begin
            resVal = sum[WIDTH-1:0];
            ovfVal = sum[WIDTH];
            finish = 1'b1;
          end
          OpSub: begin
            resVal = aReg - bReg;
            ovfVal = aReg < bReg;
            finish = 1'b1;
          end
          OpMul: begin
            if (mulCnt == LAST) begin
              resVal = partial[WIDTH-1:0];
              ovfVal = |partial[2*WIDTH-1:WIDTH];
              finish = 1'b1;
            end else begin
              prodNext = partial;
              cntNext  = mulCnt + 1'b1;
            end
          end
          default: begin
            resVal = accQ;
            ovfVal = 1'b1;
            finish = 1'b1;
          end
        endcase
`ifdef ALU_SAT_EN
        if (ovfVal) begin
          if (opReg == OpAdd || opReg == OpMul) resVal = '1;
          else if (opReg == OpSub)              resVal = '0;
        end
`endif
        if (finish) begin
          accNext    = resVal;
          resultNext = resVal;
          ovfNext    = ovfVal;
          doneNext   = 1'b1;
          cntNext    = '0;
          stateNext  = ovfVal ? ERROR : READY;
        end
      end
      ERROR: stateNext = READY;
      default: stateNext = OFF;
    endcase
  end

  // Reset beats power-down, which beats normal operation; both abandon any op in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ  <= OFF;
      accQ    <= '0;
      resultQ <= '0;
      doneQ   <= 1'b0;
      ovfQ    <= 1'b0;
      aReg    <= '0;
      bReg    <= '0;
      opReg   <= '0;
      mulCnt  <= '0;
      prodReg <= '0;
    end else if (!on) begin
      stateQ  <= OFF;
      doneQ   <= 1'b0;
      mulCnt  <= '0;
    end else begin
      stateQ  <= stateNext;
      accQ    <= accNext;
      resultQ <= resultNext;
      doneQ   <= doneNext;
      ovfQ    <= ovfNext;
      aReg    <= aNext;
      bReg    <= bNext;
      opReg   <= opNext;
      mulCnt  <= cntNext;
      prodReg <= prodNext;
    end
  end

  assign busy   = (stateQ == RUN);
  assign err    = (stateQ == ERROR);
  assign state  = stateQ;
  assign done   = doneQ;
  assign result = resultQ;
  assign acc    = accQ;
  assign ovf    = ovfQ;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Self-checking bench for acc_alu_seq (WIDTH=8): directed vector table, abort/drop corner sequences, random ops vs a reference model.
module tb_acc_alu_seq;

  localparam int W   = 8;
  localparam int MOD = 1 << W;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         on = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   in_sel = 2'b00;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, ovf, err;
  logic [W-1:0] result, acc;
  logic [1:0]   state;

  int testsRun = 0;
  int failCount = 0;
  int modelAcc = 0;

  acc_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .on(on), .start(start), .in_sel(in_sel), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .result(result), .acc(acc), .ovf(ovf), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   o;
    logic [W-1:0] expRes;
    logic         expOvf;
  } vecT;

  vecT vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic void refModel(input int sel, input int a, input int b, input int o, input int accIn,
                                   output int res, output int ovfE, output int lat);
    int A;
    longint full;
    A = (sel == 1) ? a : (sel == 2) ? 0 : accIn;
    lat = 1;
    ovfE = 0;
    case (o)
      0: res = A & b;
      1: res = A | b;
      2: res = A ^ b;
      3: res = (MOD - 1) - A;
      4: begin
        full = longint'(A) + b;
        ovfE = (full >= MOD) ? 1 : 0;
        res = int'(full % MOD);
        if (SAT && ovfE == 1) res = MOD - 1;
      end
      5: begin
        ovfE = (A < b) ? 1 : 0;
        res = (A - b + MOD) % MOD;
        if (SAT && ovfE == 1) res = 0;
      end
      6: begin
        full = longint'(A) * b;
        ovfE = (full >= MOD) ? 1 : 0;
        res = int'(full % MOD);
        lat = W;
        if (SAT && ovfE == 1) res = MOD - 1;
      end
      default: begin
        res = accIn;
        ovfE = 1;
      end
    endcase
  endfunction

  // Issue one op from READY and wait (bounded) for done; inputs are scrambled once captured.
  task automatic applyStimulus(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] o, output int lat, output logic timedOut);
    in_sel = sel; operand_a = a; operand_b = b; op = o; start = 1'b1;
    tick();
    start = 1'b0;
    in_sel = 2'($urandom_range(0, 3));
    op = 3'($urandom_range(0, 7));
    operand_a = W'($urandom_range(0, MOD - 1));
    operand_b = W'($urandom_range(0, MOD - 1));
    lat = 0;
    timedOut = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("busyDuringRun", busy, 1);
      tick();
      lat++;
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] o, input int expRes, input int expOvf, input int expLat);
    int lat;
    logic timedOut;
    applyStimulus(sel, a, b, o, lat, timedOut);
    checkOutput({tag, ".timeout"}, timedOut, 0);
    checkOutput({tag, ".latency"}, lat, expLat);
    checkOutput({tag, ".result"}, result, expRes);
    checkOutput({tag, ".acc"}, acc, expRes);
    checkOutput({tag, ".ovf"}, ovf, expOvf);
    checkOutput({tag, ".state"}, state, (expOvf != 0) ? 3 : 1);
    checkOutput({tag, ".err"}, err, expOvf);
    tick();
    checkOutput({tag, ".donePulse"}, done, 0);
    checkOutput({tag, ".backReady"}, state, 1);
    checkOutput({tag, ".errClear"}, err, 0);
    modelAcc = expRes;
  endtask

  initial begin
    int lat, expRes, expOvf, expLat;
    logic timedOut;

    vecs[0]  = '{2'b01, 8'd5,   8'd3,   3'd4, 8'd8,  1'b0};
    vecs[1]  = '{2'b00, 8'd0,   8'd2,   3'd4, 8'd10, 1'b0};
    vecs[2]  = '{2'b01, 8'd200, 8'd100, 3'd4, SAT ? 8'hFF : 8'h2C, 1'b1};
    vecs[3]  = '{2'b01, 8'd3,   8'd5,   3'd5, SAT ? 8'h00 : 8'hFE, 1'b1};
    vecs[4]  = '{2'b01, 8'd15,  8'd17,  3'd6, 8'hFF, 1'b0};
    vecs[5]  = '{2'b01, 8'd16,  8'd16,  3'd6, SAT ? 8'hFF : 8'h00, 1'b1};
    vecs[6]  = '{2'b10, 8'd77,  8'h5A,  3'd1, 8'h5A, 1'b0};
    vecs[7]  = '{2'b00, 8'd0,   8'h0F,  3'd0, 8'h0A, 1'b0};
    vecs[8]  = '{2'b00, 8'd0,   8'hFF,  3'd2, 8'hF5, 1'b0};
    vecs[9]  = '{2'b00, 8'd0,   8'd0,   3'd3, 8'h0A, 1'b0};
    vecs[10] = '{2'b11, 8'd99,  8'd1,   3'd7, 8'h0A, 1'b1};
    vecs[11] = '{2'b01, 8'd255, 8'd1,   3'd6, 8'hFF, 1'b0};
    vecs[12] = '{2'b01, 8'd0,   8'd0,   3'd5, 8'h00, 1'b0};
    vecs[13] = '{2'b01, 8'd255, 8'd1,   3'd4, SAT ? 8'hFF : 8'h00, 1'b1};

    rst = 1'b0; on = 1'b1;
    tick();
    tick();
    checkOutput("rst.state", state, 0);
    checkOutput("rst.acc", acc, 0);
    checkOutput("rst.result", result, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.ovf", ovf, 0);
    checkOutput("rst.err", err, 0);
    rst = 1'b1;
    tick();
    checkOutput("powerUp.state", state, 1);

    for (int i = 0; i < 14; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].o,
            int'(vecs[i].expRes), int'(vecs[i].expOvf), (vecs[i].o == 3'd6) ? W : 1);
    end

    // Reset in the 4th RUN cycle of a MULT: op abandoned, no done.
    in_sel = 2'b01; operand_a = 8'd7; operand_b = 8'd9; op = 3'd6; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("abortRst.noDone", done, 0);
      tick();
    end
    checkOutput("abortRst.busy", busy, 1);
    rst = 1'b0;
    tick();
    checkOutput("abortRst.state", state, 0);
    checkOutput("abortRst.acc", acc, 0);
    checkOutput("abortRst.result", result, 0);
    checkOutput("abortRst.busy", busy, 0);
    checkOutput("abortRst.done", done, 0);
    rst = 1'b1;
    tick();
    checkOutput("abortRst.ready", state, 1);
    checkOutput("abortRst.noDoneAfter", done, 0);
    modelAcc = 0;

    // Start pulse while busy is dropped; operands frozen.
    in_sel = 2'b01; operand_a = 8'd6; operand_b = 8'd7; op = 3'd6; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    timedOut = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) begin start = 1'b1; op = 3'd4; operand_a = 8'd1; operand_b = 8'd200; end
      if (i == 2) start = 1'b0;
      tick();
      lat++;
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkOutput("busyStart.timeout", timedOut, 0);
    checkOutput("busyStart.latency", lat, W);
    checkOutput("busyStart.result", result, 42);
    checkOutput("busyStart.acc", acc, 42);
    checkOutput("busyStart.ovf", ovf, 0);
    tick();
    checkOutput("busyStart.ready", state, 1);
    tick();
    checkOutput("busyStart.notQueued", state, 1);
    checkOutput("busyStart.noExtraDone", done, 0);
    modelAcc = 42;

    // Power drop mid-MULT keeps acc; start while OFF is ignored.
    in_sel = 2'b01; operand_a = 8'd3; operand_b = 8'd3; op = 3'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    on = 1'b0;
    tick();
    checkOutput("onDrop.state", state, 0);
    checkOutput("onDrop.acc", acc, 42);
    checkOutput("onDrop.busy", busy, 0);
    checkOutput("onDrop.done", done, 0);
    start = 1'b1;
    tick();
    checkOutput("onDrop.startIgnored", state, 0);
    start = 1'b0; on = 1'b1;
    tick();
    checkOutput("onDrop.ready", state, 1);
    checkOutput("onDrop.accKept", acc, 42);
    checkOutput("onDrop.noDone", done, 0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]   s;
      logic [W-1:0] a, b;
      logic [2:0]   o;
      s = 2'($urandom_range(0, 3));
      a = W'($urandom_range(0, MOD - 1));
      b = W'($urandom_range(0, MOD - 1));
      o = 3'($urandom_range(0, 7));
      refModel(int'(s), int'(a), int'(b), int'(o), modelAcc, expRes, expOvf, expLat);
      runOp($sformatf("rand%0d", n), s, a, b, o, expRes, expOvf, expLat);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/acc_alu_seq.md
Name: acc_alu_seq

Overview:
Parametrised successor to the 8-bit accumulator ALU. It is a WIDTH-bit accumulator datapath with a start/done handshake and an explicit off/ready/run/error FSM. MULT runs as an iterative shift-add over WIDTH cycles; all other ops take one cycle. The block sits between operand registers/input muxing and the output mux, replacing the fixed-width single-cycle ALU core.

Parameters:
WIDTH, 8, operand/accumulator/result width in bits (legal: >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
on  input  1  power enable; 0 forces OFF
start  input  1  request one operation; sampled only in READY
in_sel  input  2  A-operand source: 00 persist (acc), 01 load operand_a, 10 clear (0), 11 = persist
op  input  3  000 AND, 001 OR, 010 XOR, 011 NOT(A), 100 ADD, 101 SUB, 110 MULT, 111 illegal
operand_a  input  WIDTH  load value for A
operand_b  input  WIDTH  B operand
busy  output  1  high while state==RUN
done  output  1  one-cycle pulse when result/acc updated
result  output  WIDTH  last completed result (registered)
acc  output  WIDTH  accumulator value (equals result after each op)
ovf  output  1  overflow of last op; valid with done, held until next start
err  output  1  high while state==ERROR
state  output  2  current state: 00 OFF, 01 READY, 10 RUN, 11 ERROR

Behaviour:
- Reset (rst==0 at edge): state=OFF, acc=0, result=0, done=0, busy=0, ovf=0, err=0, multiplier counter=0. Reset wins over every other input, including mid-operation; an op in flight is abandoned and produces no done.
- on==0 at any edge (rst==1): state->OFF, busy=0, done=0, acc/result retained, in-flight op abandoned.
- OFF: on==1 -> READY next edge. start ignored.
- READY: start==1 -> capture A (per in_sel), B=operand_b, op; clear ovf; state->RUN. start==0 -> stay.
- RUN, single-cycle ops (AND/OR/XOR/NOT/ADD/SUB): at the first edge in RUN, write result and acc, set done=1 for one cycle. State->ERROR if ovf else READY. Latency: start sampled at edge k, done high in the cycle after edge k+1.
- RUN, MULT: shift-add over exactly WIDTH edges, with a 2*WIDTH-bit product. Result is the low WIDTH bits. Done follows edge k+WIDTH. Operands are frozen during RUN; input changes have no effect.
- Arithmetic: ADD ovf = carry out of WIDTH bits. SUB = A-B mod 2^WIDTH, ovf = borrow (A<B). MULT ovf = upper WIDTH bits nonzero. Logic ops: ovf=0.
- Illegal op 111: completes in one cycle, result/acc unchanged, ovf=1, done pulses, state->ERROR.
- ERROR: err=1 for exactly one cycle, then ->READY unconditionally. start is ignored in ERROR.
- start while busy/ERROR/OFF is dropped (not queued).
- done and the state transition leaving RUN occur at the same edge. A new start can be accepted in the first READY cycle after done.

Optional Feature:
ALU_SAT_EN
- Defined: on ovf, ADD and MULT results saturate to all-ones and SUB saturates to 0. Logic ops and the illegal op are unaffected. ovf and the ERROR transition are unchanged.
- Undefined: results wrap (low WIDTH bits), as stated above.

Test Plan:
- WIDTH=8. on=1; in_sel=01 operand_a=5, op=ADD, operand_b=3, start -> done after 1 cycle, result=acc=8, ovf=0. Then in_sel=00, ADD, B=2 -> acc=10.
- Load 200, ADD B=100 -> result 0x2C, ovf=1, err high one cycle, then READY. With ALU_SAT_EN: result 0xFF.
- Load 3, SUB B=5 -> result 0xFE, ovf=1. With ALU_SAT_EN: result 0x00.
- Load 15, MULT B=17 -> busy for 8 cycles, done at edge k+8, result 0xFF, ovf=0. Load 16, MULT B=16 -> result 0x00, ovf=1 (saturated: 0xFF).
- Start MULT, drop rst low in the 4th RUN cycle -> next edge state=OFF, acc=0, busy=0, no done. Pulse start during busy -> ignored, result unaffected.
- Start MULT, drop on to 0 mid-RUN -> state=OFF, acc keeps its prior value. Raise on -> READY after 1 edge. op=111 -> acc unchanged, ovf=1, ERROR one cycle.
